vga_scanout: RTL and testbench

//  Read-side master for the CPU-written VGA frame buffer (vga_ram): CPU writes pixels,

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_sync_gen.sv | 55 +++++
 rtl/vga_scanout.sv | 127 ++++++++++++
 tb/tb_vga_scanout.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing plus the counter and pipeline types
// shared by the scan-out blocks.
`timescale 1ns/1ps
package vga_timing_pkg;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [9:0] hcnt_t;
  typedef logic [9:0] vcnt_t;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic active;
    logic frame_start;
    logic in_img;
  } raster_t;

  // Idle raster: syncs deasserted (high), everything else off.
  localparam raster_t RASTER_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0,
                                      frame_start: 1'b0, in_img: 1'b0};

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: horizontal/vertical raster counters and the raw (stage 0) sync,
// active-video and frame-start strobes decoded from them.
`timescale 1ns/1ps
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic  clk,
  input  logic  reset,
  output hcnt_t h_cnt,
  output vcnt_t v_cnt,
  output logic  line_end,
  output logic  frame_end,
  output logic  hsync_raw,
  output logic  vsync_raw,
  output logic  active_raw,
  output logic  frame_start_raw
);
  localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  assign line_end  = (h_cnt == hcnt_t'(H_TOT - 1));
  assign frame_end = line_end && (v_cnt == vcnt_t'(V_TOT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= frame_end ? '0 : v_cnt + vcnt_t'(1);
    end else begin
      h_cnt <= h_cnt + hcnt_t'(1);
    end
  end

  always_comb begin
    hsync_raw       = !((h_cnt >= hcnt_t'(HS_BEG)) && (h_cnt < hcnt_t'(HS_END)));
    vsync_raw       = !((v_cnt >= vcnt_t'(VS_BEG)) && (v_cnt < vcnt_t'(VS_END)));
    active_raw      = (h_cnt < hcnt_t'(H_ACTIVE)) && (v_cnt < vcnt_t'(V_ACTIVE));
    frame_start_raw = (h_cnt == '0) && (v_cnt == '0);
  end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: frame-buffer read master producing grayscale 640x480@60 video.
// Define VGA_SCANOUT_SCALE2_EN for 2x pixel doubling of the stored image.
`timescale 1ns/1ps
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] vga_pixel_addr,
  input  logic [7:0]        vga_pixel_val,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              sync_n,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_start
);
`ifdef VGA_SCANOUT_SCALE2_EN
  localparam int unsigned SCALE_SH = 1;
`else
  localparam int unsigned SCALE_SH = 0;
`endif
  // On-screen image extent, clipped to the active area.
  localparam int unsigned SCR_W = min_u(IMG_W << SCALE_SH, H_ACTIVE);
  localparam int unsigned SCR_H = min_u(IMG_H << SCALE_SH, V_ACTIVE);
  localparam int unsigned DEPTH = RD_LAT + 1;

  hcnt_t             h_cnt;
  vcnt_t             v_cnt;
  logic              line_end, frame_end;
  logic              hsync_raw, vsync_raw, active_raw, frame_start_raw;
  logic              in_img, row_step;
  hcnt_t             col;
  logic [ADDR_W-1:0] row_base;
  raster_t           raw;
  raster_t           pipe [DEPTH];
  logic [7:0]        pix;

  vga_sync_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_sync (
    .clk            (clk),
    .reset          (reset),
    .h_cnt          (h_cnt),
    .v_cnt          (v_cnt),
    .line_end       (line_end),
    .frame_end      (frame_end),
    .hsync_raw      (hsync_raw),
    .vsync_raw      (vsync_raw),
    .active_raw     (active_raw),
    .frame_start_raw(frame_start_raw)
  );

  always_comb begin
    in_img          = (h_cnt < hcnt_t'(SCR_W)) && (v_cnt < vcnt_t'(SCR_H));
    col             = h_cnt >> SCALE_SH;
    row_step        = (SCALE_SH == 0) || v_cnt[0];
    raw             = RASTER_IDLE;
    raw.hsync_n     = hsync_raw;
    raw.vsync_n     = vsync_raw;
    raw.active      = active_raw;
    raw.frame_start = frame_start_raw;
    raw.in_img      = in_img;
  end

  // row_base tracks v*IMG_W (or (v>>1)*IMG_W) so the address needs only an adder.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_base <= '0;
    end else if (line_end) begin
      if (frame_end)     row_base <= '0;
      else if (row_step) row_base <= row_base + ADDR_W'(IMG_W);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) vga_pixel_addr <= '0;
    else        vga_pixel_addr <= in_img ? row_base + ADDR_W'(col) : '0;
  end

  // Control strobes ride alongside the fetch so they meet the returning data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= RASTER_IDLE;
    end else begin
      pipe[0] <= raw;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
      pix         <= '0;
    end else begin
      hsync       <= pipe[DEPTH-1].hsync_n;
      vsync       <= pipe[DEPTH-1].vsync_n;
      blank_n     <= pipe[DEPTH-1].active;
      frame_start <= pipe[DEPTH-1].frame_start;
      pix         <= (pipe[DEPTH-1].active && pipe[DEPTH-1].in_img) ? vga_pixel_val : '0;
    end
  end

  assign r      = pix;
  assign g      = pix;
  assign b      = pix;
  assign sync_n = 1'b0;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout with a latency-1 RAM model
// (data = addr[7:0]); vertical timing shortened to keep frames short.
`timescale 1ns/1ps
module tb_vga_scanout;
  localparam int unsigned H_TOT  = vga_timing_pkg::H_TOTAL;
  localparam int unsigned V_ACT  = 24;
  localparam int unsigned V_FP   = 2;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 2;
  localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME  = H_TOT * V_TOT;
`ifdef VGA_SCANOUT_SCALE2_EN
  localparam int unsigned IMG_W = 320;
  localparam int unsigned IMG_H = 240;
`else
  localparam int unsigned IMG_W = 256;
  localparam int unsigned IMG_H = 256;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] vga_pixel_addr;
  logic [7:0]  vga_pixel_val;
  logic        hsync, vsync, blank_n, sync_n, frame_start;
  logic [7:0]  r, g, b;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          done = 0;

  typedef struct {
    logic [7:0] rgb;
    logic       blank_n;
  } exp_t;
  exp_t sb[$];

  vga_scanout #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(1), .ADDR_W(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vga_pixel_addr(vga_pixel_addr),
    .vga_pixel_val (vga_pixel_val),
    .hsync         (hsync),
    .vsync         (vsync),
    .blank_n       (blank_n),
    .sync_n        (sync_n),
    .r             (r),
    .g             (g),
    .b             (b),
    .frame_start   (frame_start)
  );

  always #20 clk = ~clk;

  // RAM model plus a count of clock edges since the last reset-low edge.
  always @(posedge clk) begin
    vga_pixel_val <= vga_pixel_addr[7:0];
    cyc <= reset ? cyc + 1 : 0;
  end

  function automatic bit model_in_img(input int unsigned x, input int unsigned y);
`ifdef VGA_SCANOUT_SCALE2_EN
    return (x < 2 * IMG_W) && (x < 640) && (y < 2 * IMG_H) && (y < V_ACT);
`else
    return (x < IMG_W) && (x < 640) && (y < IMG_H) && (y < V_ACT);
`endif
  endfunction

  function automatic logic [31:0] model_addr(input int unsigned x, input int unsigned y);
    if (!model_in_img(x, y)) return 32'd0;
`ifdef VGA_SCANOUT_SCALE2_EN
    return (y / 2) * IMG_W + x / 2;
`else
    return y * IMG_W + x;
`endif
  endfunction

  function automatic int unsigned next_at(input int unsigned x, input int unsigned y,
                                          input int unsigned off);
    int unsigned t;
    t = (cyc / FRAME) * FRAME + y * H_TOT + x + off;
    if (t <= cyc) t += FRAME;
    return t;
  endfunction

  task automatic wait_cyc(input int unsigned target, output bit ok);
    int unsigned n;
    n  = 0;
    ok = 1'b1;
    while (cyc != target) begin
      @(negedge clk);
      n++;
      if (n > 2 * FRAME) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_pixel(input string name, input int unsigned x, input int unsigned y,
                            input logic [31:0] e_addr, input logic [7:0] e_rgb,
                            input logic e_blank);
    exp_t e;
    bit   ok;
    wait_cyc(next_at(x, y, 1), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_wait: cycle %0d never reached", name, next_at(x, y, 1));
      return;
    end
    if (vga_pixel_addr !== e_addr) begin
      fails++;
      $display("FAIL %s_addr: got %0d, required %0d", name, vga_pixel_addr, e_addr);
    end
    e.rgb     = e_rgb;
    e.blank_n = e_blank;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (r !== e.rgb || g !== e.rgb || b !== e.rgb) begin
      fails++;
      $display("FAIL %s_rgb: got %02h/%02h/%02h, required %02h", name, r, g, b, e.rgb);
    end
    tests++;
    if (blank_n !== e.blank_n) begin
      fails++;
      $display("FAIL %s_blank_n: got %b, required %b", name, blank_n, e.blank_n);
    end
  endtask

  task automatic test_reset;
    int unsigned n;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      fails++;
      $display("FAIL reset_sync: got hsync=%b vsync=%b, required 1/1", hsync, vsync);
    end
    tests++;
    if (blank_n !== 1'b0 || frame_start !== 1'b0 || sync_n !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got blank_n=%b frame_start=%b sync_n=%b, required 0/0/0",
               blank_n, frame_start, sync_n);
    end
    tests++;
    if ({r, g, b} !== 24'h0 || vga_pixel_addr !== 32'd0) begin
      fails++;
      $display("FAIL reset_data: got rgb=%06h addr=%0d, required 0/0", {r, g, b}, vga_pixel_addr);
    end
    reset = 1'b1;
    n = 0;
    while (hsync !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (hsync !== 1'b0 || cyc != 659) begin
      fails++;
      $display("FAIL first_hsync_fall: got cycle %0d (hsync=%b), required 659", cyc, hsync);
    end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    bit          ok;
    int unsigned x;
    logic [31:0] ea;
    wait_cyc(next_at(250, 2, 1), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL b2b_wait: start cycle never reached");
      return;
    end
    for (int unsigned k = 0; k < 12; k++) begin
      if (k < 10) begin
        x  = 250 + k;
        ea = model_addr(x, 2);
        tests++;
        if (vga_pixel_addr !== ea) begin
          fails++;
          $display("FAIL b2b_addr_x%0d: got %0d, required %0d", x, vga_pixel_addr, ea);
        end
        e.rgb     = model_in_img(x, 2) ? ea[7:0] : 8'h00;
        e.blank_n = 1'b1;
        sb.push_back(e);
      end
      if (k >= 2) begin
        e = sb.pop_front();
        tests++;
        if (r !== e.rgb || g !== e.rgb || b !== e.rgb || blank_n !== e.blank_n) begin
          fails++;
          $display("FAIL b2b_pix_x%0d: got rgb=%02h blank_n=%b, required %02h/%b",
                   248 + k, r, blank_n, e.rgb, e.blank_n);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_image_pixel;
    test_pixel("pix_5_3", 5, 3, 32'd773, 8'h05, 1'b1);
  endtask

  task automatic test_outside_pixel;
    test_pixel("pix_300_10", 300, 10, 32'd0, 8'h00, 1'b1);
  endtask

  task automatic test_scale2;
    test_pixel("s2_9_7", 9, 7, 32'd964, 8'hC4, 1'b1);
    test_pixel("s2_639_last", 639, V_ACT - 1, 32'd3839, 8'hFF, 1'b1);
  endtask

  task automatic test_clip_corners;
    logic [31:0] ea;
    ea = model_addr(7, V_ACT - 1);
    test_pixel("clip_last_row", 7, V_ACT - 1, ea, ea[7:0], 1'b1);
    test_pixel("vblank_row", 5, V_ACT, 32'd0, 8'h00, 1'b0);
  endtask

  task automatic test_mid_reset;
    bit          ok;
    int unsigned fs_at, hs_at;
    wait_cyc(next_at(400, 20, 0), ok);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fs_at = 0;
    hs_at = 0;
    for (int unsigned n = 0; n < 2000 && hs_at == 0; n++) begin
      @(negedge clk);
      if (cyc < 3 && blank_n !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL mid_reset_partial: blank_n=%b at cycle %0d, required 0", blank_n, cyc);
      end
      if (frame_start === 1'b1 && fs_at == 0) fs_at = cyc;
      if (hsync === 1'b0) hs_at = cyc;
    end
    tests++;
    if (!ok || fs_at != 3) begin
      fails++;
      $display("FAIL mid_reset_frame_start: got cycle %0d, required 3", fs_at);
    end
    tests++;
    if (hs_at != 659) begin
      fails++;
      $display("FAIL mid_reset_hsync_fall: got cycle %0d, required 659", hs_at);
    end
  endtask

  task automatic test_frame_timing;
    int unsigned hf[$], hr[$], vf[$], vr[$], fs[$];
    int unsigned h_low, v_low;
    logic        ph, pv;
    ph = hsync;
    pv = vsync;
    for (int unsigned n = 0; n < 2 * FRAME + 1000 && !(vf.size() >= 2 && fs.size() >= 2); n++) begin
      @(negedge clk);
      if (ph === 1'b1 && hsync === 1'b0) hf.push_back(cyc);
      if (ph === 1'b0 && hsync === 1'b1) hr.push_back(cyc);
      if (pv === 1'b1 && vsync === 1'b0) vf.push_back(cyc);
      if (pv === 1'b0 && vsync === 1'b1) vr.push_back(cyc);
      if (frame_start === 1'b1) fs.push_back(cyc);
      ph = hsync;
      pv = vsync;
    end
    h_low = 0;
    v_low = 0;
    if (hf.size() > 0) foreach (hr[i]) if (h_low == 0 && hr[i] > hf[0]) h_low = hr[i] - hf[0];
    if (vf.size() > 0) foreach (vr[i]) if (v_low == 0 && vr[i] > vf[0]) v_low = vr[i] - vf[0];
    tests++;
    if (hf.size() < 2 || hf[1] - hf[0] != H_TOT) begin
      fails++;
      $display("FAIL hsync_period: got %0d, required %0d",
               (hf.size() < 2) ? 0 : hf[1] - hf[0], H_TOT);
    end
    tests++;
    if (h_low != 96) begin
      fails++;
      $display("FAIL hsync_low: got %0d, required 96", h_low);
    end
    tests++;
    if (vf.size() < 2 || vf[1] - vf[0] != FRAME) begin
      fails++;
      $display("FAIL vsync_period: got %0d, required %0d",
               (vf.size() < 2) ? 0 : vf[1] - vf[0], FRAME);
    end
    tests++;
    if (v_low != 2 * H_TOT) begin
      fails++;
      $display("FAIL vsync_low: got %0d, required %0d", v_low, 2 * H_TOT);
    end
    tests++;
    if (fs.size() < 2 || fs[1] - fs[0] != FRAME) begin
      fails++;
      $display("FAIL frame_start_period: got %0d, required %0d",
               (fs.size() < 2) ? 0 : fs[1] - fs[0], FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
`ifdef VGA_SCANOUT_SCALE2_EN
    test_scale2();
`else
    test_image_pixel();
    test_outside_pixel();
`endif
    test_mid_reset();
    test_clip_corners();
    test_frame_timing();
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(40 * 150000);
    if (!done) begin
      $display("FAIL watchdog: simulation exceeded 150000 cycles");
      $fatal(1, "watchdog");
    end
  end
endmodule
